tt_um_alu_decoders: RTL and testbench
=====================================

// Module: tt_um_alu_decoders
// PURPOSE
//  Tiny Tapeout user tile: 3-bit ALU with selectable output decoding.
//  Operands A and B plus a 2-bit opcode on ui_in produce a 6-bit result R.
//  uio_in[7] selects the output format:
//   - octal mode: two 7-segment digits;
//   - Gray mode: Gray-coded binary.
//  Datapath is combinational; clk/rst_n serve only the optional output register.
// PARAMETERS
//  none (fixed TT tile interface)
// PORTS
//  clk      in   1  clock, single clock domain; rising edge
//  rst_n    in   1  reset, asynchronous, active-low
//  ena      in   1  tile selected; ignored
//  ui_in    in   8  [7:5]=A, [4:2]=B, [1:0]=OP
//  uo_out   out  8  primary result (format per MODE)
//  uio_in   in   8  [7]=MODE (0=octal, 1=Gray); [6:0] ignored
//  uio_out  out  8  octal upper digit; [7] always 0
//  uio_oe   out  8  constant 8'h7F (uio[7] input, uio[6:0] outputs)
// BEHAVIOUR
//  Operands unsigned 3-bit; R is 6-bit:
//   OP=00 ADD: R=A+B (0..14)
//   OP=01 SUB: R=(A-B) mod 64, two's complement wrap (3-5 -> 6'o76)
//   OP=10 MUL: R=A*B (0..49)
//   OP=11 AND: R={3'b0, A&B}
//  Z = (R==0).
//  7-seg code, bit0=a..bit6=g, active high:
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//  MODE=0 (octal):
//   uo_out  = {Z, SEG(R[2:0])}
//   uio_out = {1'b0, SEG(R[5:3])}
//  MODE=1 (Gray):
//   uo_out  = {Z, 1'b0, R^(R>>1)}
//   uio_out = 8'h00
//  Outputs follow any ui_in/uio_in change combinationally (zero latency).
//  All 64 operand combinations are legal; no X-propagation paths.
// CONFIGURATION
//  Macro OUTPUT_REG_EN.
//  Defined:
//   - uo_out/uio_out registered on rising clk; latency 1 cycle.
//   - rst_n low asynchronously forces both to 8'h00.
//   - Registers hold 0 until the first clk edge after release.
//  Undefined:
//   - Purely combinational as above; clk and rst_n have no effect.
//  uio_oe is 8'h7F in both builds, including during reset.
// STRUCTURE
//  Package alu_dec_pkg:
//   - op enum (OP_ADD, OP_SUB, OP_MUL, OP_AND)
//   - mode enum (MODE_OCT, MODE_GRAY)
//   - SEG7 lookup constant, 8 entries
//  Sub-module seg7_oct_decoder: 3-bit digit -> 7-bit segments.
//   Instantiated twice (low and high digit).
//  Top holds ALU mux, Gray conversion, output mux, optional register.
// TESTING (combinational build; registered build checks same values 1 clk later)
//  A=7,B=7, MODE=0:
//   OP0 -> uo=7D uio=06
//   OP1 -> uo=BF uio=3F
//   OP2 -> uo=06 uio=7D
//   OP3 -> uo=07 uio=3F
//  A=7,B=7, MODE=1:
//   OP0 -> 09, OP1 -> 80, OP2 -> 29, OP3 -> 04; uio=00 throughout
//  A=5,B=3, MODE=0:
//   OP0 -> uo=3F uio=06
//   OP1 -> uo=5B uio=3F
//   OP2 -> uo=07 uio=06
//   OP3 -> uo=06 uio=3F
//  A=5,B=3, MODE=1:
//   OP0 -> 0C, OP1 -> 03, OP2 -> 08, OP3 -> 01
//  SUB wrap, A=3,B=5, MODE=0, OP=01:
//   uo=7D uio=07 (6'o76)
//  OUTPUT_REG_EN build:
//   - assert rst_n mid-operation -> uo/uio=00 immediately, uio_oe stays 7F
//   - release rst_n -> output after first clk edge

Source files
------------

// File: rtl/tt_um_alu_decoders_pkg.sv
// Shared types and constants for the ALU/decoder tile: opcode and output-mode
// enums plus the 7-segment lookup used by the octal digit decoders.
package alu_dec_pkg;

  // Two-bit ALU opcode carried on ui_in[1:0]
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } op_e;

  // Output format selected by uio_in[7]
  typedef enum logic {
    MODE_OCT  = 1'b0,
    MODE_GRAY = 1'b1
  } mode_e;

  // Segment patterns for octal digits, bit0=a .. bit6=g, active high
  localparam logic [6:0] SEG7 [0:7] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

  // Output-enable pattern: uio[7] is the mode input, uio[6:0] drive the upper digit
  localparam logic [7:0] UIO_OE_VAL = 8'h7F;

endpackage

// File: rtl/tt_um_alu_decoders_seg7.sv
// Octal digit to 7-segment decoder (bit0=a .. bit6=g, active high).
module seg7_oct_decoder
  import alu_dec_pkg::*;
(
  input  logic [2:0] i_digit,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern for one octal digit
  always_comb begin
    o_seg = SEG7[i_digit];
  end

endmodule

// File: rtl/tt_um_alu_decoders.sv
// Tiny Tapeout tile: 3-bit ALU (ADD/SUB/MUL/AND) producing a 6-bit result,
// shown either as two octal 7-segment digits or as Gray-coded binary.
// Optional build macro OUTPUT_REG_EN registers uo_out/uio_out (1-cycle latency,
// async active-low reset to zero); without it the tile is purely combinational.
module tt_um_alu_decoders
  import alu_dec_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [2:0] w_a;
  logic [2:0] w_b;
  op_e        w_op;
  mode_e      w_mode;
  logic [5:0] w_r;
  logic       w_z;
  logic [5:0] w_gray;
  logic [6:0] w_seg_lo;
  logic [6:0] w_seg_hi;
  logic [7:0] w_uo;
  logic [7:0] w_uio;

  assign w_a    = ui_in[7:5];
  assign w_b    = ui_in[4:2];
  assign w_op   = op_e'(ui_in[1:0]);
  assign w_mode = mode_e'(uio_in[7]);

  // ALU: operands zero-extended to 6 bits so SUB wraps modulo 64
  always_comb begin
    w_r = 6'd0;
    case (w_op)
      OP_ADD:  w_r = {3'b000, w_a} + {3'b000, w_b};
      OP_SUB:  w_r = {3'b000, w_a} - {3'b000, w_b};
      OP_MUL:  w_r = {3'b000, w_a} * {3'b000, w_b};
      OP_AND:  w_r = {3'b000, w_a & w_b};
      default: w_r = 6'd0;
    endcase
  end

  assign w_z    = (w_r == 6'd0);
  assign w_gray = w_r ^ (w_r >> 1);

  seg7_oct_decoder u_seg_lo (
    .i_digit (w_r[2:0]),
    .o_seg   (w_seg_lo)
  );

  seg7_oct_decoder u_seg_hi (
    .i_digit (w_r[5:3]),
    .o_seg   (w_seg_hi)
  );

  // Output format mux: octal digits or Gray code, zero flag on bit 7
  always_comb begin
    w_uo  = 8'h00;
    w_uio = 8'h00;
    if (w_mode == MODE_GRAY) begin
      w_uo  = {w_z, 1'b0, w_gray};
      w_uio = 8'h00;
    end else begin
      w_uo  = {w_z, w_seg_lo};
      w_uio = {1'b0, w_seg_hi};
    end
  end

  assign uio_oe = UIO_OE_VAL;

`ifdef OUTPUT_REG_EN
  logic [7:0] r_uo;
  logic [7:0] r_uio;
  logic       w_unused;

  // Output register: async clear on reset, capture formatted result each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo  <= 8'h00;
      r_uio <= 8'h00;
    end else begin
      r_uo  <= w_uo;
      r_uio <= w_uio;
    end
  end

  assign uo_out   = r_uo;
  assign uio_out  = r_uio;
  assign w_unused = &{1'b0, ena, uio_in[6:0]};
`else
  logic w_unused;

  assign uo_out   = w_uo;
  assign uio_out  = w_uio;
  assign w_unused = &{1'b0, ena, clk, rst_n, uio_in[6:0]};
`endif

endmodule

// File: tb/tb_tt_um_alu_decoders.sv
// Self-checking bench for tt_um_alu_decoders. Expected values come from the
// documented vector table and from an independent arithmetic model; they are
// queued when stimulus is driven and compared when the output is due.
// Works for both builds: OUTPUT_REG_EN adds one clock of latency and reset checks.
module tb_tt_um_alu_decoders;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  logic [6:0] seg_tb [0:7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  tt_um_alu_decoders dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op, input int mode);
    int   r;
    exp_t e;
    case (op)
      0:       r = a + b;
      1:       r = (a - b + 64) % 64;
      2:       r = a * b;
      default: r = a & b;
    endcase
    if (mode == 1) begin
      e.uo  = {(r == 0) ? 1'b1 : 1'b0, 1'b0, 6'(r ^ (r / 2))};
      e.uio = 8'h00;
    end else begin
      e.uo  = {(r == 0) ? 1'b1 : 1'b0, seg_tb[r % 8]};
      e.uio = {1'b0, seg_tb[r / 8]};
    end
    return e;
  endfunction

  task automatic drive(input int a, input int b, input int op, input int mode);
    ui_in  = {3'(a), 3'(b), 2'(op)};
    uio_in = {1'(mode), 7'h55};
  endtask

  task automatic settle();
`ifdef OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic collect(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_uo"}, uo_out, e.uo);
      check_eq({tag, "_uio"}, uio_out, e.uio);
      check_eq({tag, "_oe"}, uio_oe, 8'h7F);
    end
  endtask

  // One vector with its expectation taken from the documented table
  task automatic vec_k(input string tag, input int a, input int b, input int op, input int mode,
                       input logic [7:0] uo, input logic [7:0] uio);
    exp_t e;
    @(negedge clk);
    drive(a, b, op, mode);
    e.uo  = uo;
    e.uio = uio;
    sb_q.push_back(e);
    settle();
    collect(tag);
  endtask

  // One vector with its expectation from the model
  task automatic vec_m(input int a, input int b, input int op, input int mode);
    @(negedge clk);
    drive(a, b, op, mode);
    sb_q.push_back(model(a, b, op, mode));
    settle();
    collect($sformatf("sw_a%0d_b%0d_op%0d_m%0d", a, b, op, mode));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    ena    = 1'b1;
    rst_n  = 1'b0;
    drive(7, 7, 0, 0);
    #3;
`ifdef OUTPUT_REG_EN
    check_eq("reset_uo", uo_out, 8'h00);
    check_eq("reset_uio", uio_out, 8'h00);
`else
    check_eq("reset_uo", uo_out, 8'h7D);
    check_eq("reset_uio", uio_out, 8'h06);
`endif
    check_eq("reset_oe", uio_oe, 8'h7F);
`ifdef OUTPUT_REG_EN
    @(posedge clk);
    #1;
    check_eq("reset_hold_uo", uo_out, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Documented vectors
    vec_k("a7b7_add_oct", 7, 7, 0, 0, 8'h7D, 8'h06);
    vec_k("a7b7_sub_oct", 7, 7, 1, 0, 8'hBF, 8'h3F);
    vec_k("a7b7_mul_oct", 7, 7, 2, 0, 8'h06, 8'h7D);
    vec_k("a7b7_and_oct", 7, 7, 3, 0, 8'h07, 8'h3F);
    vec_k("a7b7_add_gray", 7, 7, 0, 1, 8'h09, 8'h00);
    vec_k("a7b7_sub_gray", 7, 7, 1, 1, 8'h80, 8'h00);
    vec_k("a7b7_mul_gray", 7, 7, 2, 1, 8'h29, 8'h00);
    vec_k("a7b7_and_gray", 7, 7, 3, 1, 8'h04, 8'h00);
    vec_k("a5b3_add_oct", 5, 3, 0, 0, 8'h3F, 8'h06);
    vec_k("a5b3_sub_oct", 5, 3, 1, 0, 8'h5B, 8'h3F);
    vec_k("a5b3_mul_oct", 5, 3, 2, 0, 8'h07, 8'h06);
    vec_k("a5b3_and_oct", 5, 3, 3, 0, 8'h06, 8'h3F);
    vec_k("a5b3_add_gray", 5, 3, 0, 1, 8'h0C, 8'h00);
    vec_k("a5b3_sub_gray", 5, 3, 1, 1, 8'h03, 8'h00);
    vec_k("a5b3_mul_gray", 5, 3, 2, 1, 8'h08, 8'h00);
    vec_k("a5b3_and_gray", 5, 3, 3, 1, 8'h01, 8'h00);
    vec_k("sub_wrap_oct", 3, 5, 1, 0, 8'h7D, 8'h07);
    vec_k("zero_add_oct", 0, 0, 0, 0, 8'hBF, 8'h3F);

    // Reset asserted in the middle of operation
    vec_k("pre_reset", 7, 7, 2, 0, 8'h06, 8'h7D);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef OUTPUT_REG_EN
    check_eq("midrst_uo", uo_out, 8'h00);
    check_eq("midrst_uio", uio_out, 8'h00);
`else
    check_eq("midrst_uo", uo_out, 8'h06);
    check_eq("midrst_uio", uio_out, 8'h7D);
`endif
    check_eq("midrst_oe", uio_oe, 8'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef OUTPUT_REG_EN
    check_eq("release_hold_uo", uo_out, 8'h00);
    check_eq("release_hold_uio", uio_out, 8'h00);
    @(posedge clk);
    #1;
`endif
    check_eq("release_edge_uo", uo_out, 8'h06);
    check_eq("release_edge_uio", uio_out, 8'h7D);

    // Exhaustive sweep of operands, opcodes and modes against the model
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int op = 0; op < 4; op++) begin
          for (int m = 0; m < 2; m++) begin
            vec_m(a, b, op, m);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
